aes_decipher_block_par: RTL and testbench



---
 rtl/aes_decipher_block_par.sv | 204 ++++++++++++++++++++
 tb/tb_aes_decipher_block_par.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decipher_block_par.sv
// Iterative AES inverse-cipher round engine, NUM_SBOX inverse S-box words per cycle (1, 2 or 4).
// Defining AES_DEC_ABORT_EN adds an abort input that drops an operation and clears the state.
module aes_decipher_block_par #(
  parameter int unsigned NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
`ifdef AES_DEC_ABORT_EN
  input  logic         abort,
`endif
  input  logic [1:0]   keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  localparam int unsigned W = 4 / NUM_SBOX;
  localparam logic [1:0] LastCtr = 2'(W - 1);

  if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad_num_sbox
    $error("NUM_SBOX must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {StIdle, StInit, StMain} state_e;

  state_e           state_q, state_d;
  logic [127:0]     block_q, block_d;
  logic [3:0]       round_q, round_d;
  logic [1:0]       sword_ctr_q, sword_ctr_d;
  logic             ready_q, ready_d;
  logic             abort_act, start, last_sub;
  logic [3:0]       nr;
  logic [1:0]       word_idx;
  logic [3:0][31:0] cur_words, sub_words;
  logic [127:0]     add_key;

`ifdef AES_DEC_ABORT_EN
  assign abort_act = abort;
`else
  assign abort_act = 1'b0;
`endif

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0).
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] sq, res;
    sq  = x;
    res = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      res = gmul(res, sq);
    end
    return res;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) y[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8];
    return ginv(y ^ 8'h05);
  endfunction

  function automatic logic [31:0] inv_sbox_word(input logic [31:0] w);
    return {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127 - 32 * c -: 32] = inv_mix_col(s[127 - 32 * c -: 32]);
    return o;
  endfunction

  assign start     = next & ~abort_act;
  assign last_sub  = (sword_ctr_q == LastCtr);
  assign cur_words = block_q;

  always_comb begin
    unique case (keylen)
      2'b01:   nr = 4'd12;
      2'b10:   nr = 4'd14;
      default: nr = 4'd10;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StInit;
      StInit:  state_d = StMain;
      StMain:  if (last_sub && round_q == 4'd0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_act && state_q != StIdle) state_d = StIdle;
  end

  // Words are indexed MSW first; packed word 3 holds block bits [127:96].
  always_comb begin
    sub_words = cur_words;
    word_idx  = '0;
    for (int unsigned k = 0; k < NUM_SBOX; k++) begin
      word_idx = 2'(32'(sword_ctr_q) * NUM_SBOX + k);
      sub_words[2'd3 - word_idx] = inv_sbox_word(cur_words[2'd3 - word_idx]);
    end
    add_key = sub_words ^ round_key;

    block_d     = block_q;
    round_d     = round_q;
    sword_ctr_d = sword_ctr_q;
    ready_d     = ready_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          round_d = nr;
          ready_d = 1'b0;
        end
      end
      StInit: begin
        block_d = inv_shift_rows(block ^ round_key);
        round_d = round_q - 4'd1;
      end
      StMain: begin
        if (!last_sub) begin
          block_d     = sub_words;
          sword_ctr_d = sword_ctr_q + 2'd1;
        end else begin
          sword_ctr_d = '0;
          if (round_q != 4'd0) begin
            block_d = inv_shift_rows(inv_mix_columns(add_key));
            round_d = round_q - 4'd1;
          end else begin
            block_d = add_key;
            ready_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    // Abort clears the block so no partial state is visible.
    if (abort_act && state_q != StIdle) begin
      block_d     = '0;
      round_d     = '0;
      sword_ctr_d = '0;
      ready_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      block_q     <= '0;
      round_q     <= '0;
      sword_ctr_q <= '0;
      ready_q     <= 1'b1;
    end else begin
      block_q     <= block_d;
      round_q     <= round_d;
      sword_ctr_q <= sword_ctr_d;
      ready_q     <= ready_d;
    end
  end

  assign round     = round_q;
  assign new_block = block_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_aes_decipher_block_par.sv
// Directed bench: FIPS-197 C.1/C.2/C.3 decryptions on NUM_SBOX = 4, 2 and 1 instances,
// plus hand sequences for round holding, ignored/held next, async reset and optional abort.
module tb_aes_decipher_block_par;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   keylen = 2'b00;
  logic [127:0] blk = '0;
  logic         next_v [3];
  logic [3:0]   round_v [3];
  logic [127:0] rk_v [3];
  logic [127:0] nb_v [3];
  logic         ready_v [3];
  logic [127:0] rk_tab [16];
`ifdef AES_DEC_ABORT_EN
  logic         abort = 1'b0;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rk_v[0] = rk_tab[round_v[0]];
  assign rk_v[1] = rk_tab[round_v[1]];
  assign rk_v[2] = rk_tab[round_v[2]];

  aes_decipher_block_par #(.NUM_SBOX(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .next(next_v[0]),
`ifdef AES_DEC_ABORT_EN
    .abort(abort),
`endif
    .keylen(keylen), .round(round_v[0]), .round_key(rk_v[0]), .block(blk),
    .new_block(nb_v[0]), .ready(ready_v[0]));

  aes_decipher_block_par #(.NUM_SBOX(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .next(next_v[1]),
`ifdef AES_DEC_ABORT_EN
    .abort(abort),
`endif
    .keylen(keylen), .round(round_v[1]), .round_key(rk_v[1]), .block(blk),
    .new_block(nb_v[1]), .ready(ready_v[1]));

  aes_decipher_block_par #(.NUM_SBOX(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .next(next_v[2]),
`ifdef AES_DEC_ABORT_EN
    .abort(abort),
`endif
    .keylen(keylen), .round(round_v[2]), .round_key(rk_v[2]), .block(blk),
    .new_block(nb_v[2]), .ready(ready_v[2]));

  // Forward S-box and key schedule: the bench acts as the key memory.
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, b;
    inv = 8'h00;
    for (int c = 1; c < 256; c++) if (gm(x, 8'(c)) == 8'h01) inv = 8'(c);
    for (int i = 0; i < 8; i++)
      b[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
    return b ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  task automatic expand(input logic [255:0] key, input logic [1:0] kl);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = (kl == 2'b01) ? 6 : (kl == 2'b10) ? 8 : 4;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_tab[r] = '0;
    for (int r = 0; r <= nr; r++) rk_tab[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge; the following edge samples next.
  task automatic start(input int d);
    next_v[d] = 1'b1;
    tick();
    next_v[d] = 1'b0;
  endtask

  // Latency counts rising edges from (and including) the one that sampled next.
  task automatic wait_ready(input int d, input int init, output int cyc);
    cyc = init;
    while (!ready_v[d] && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic setup(input logic [255:0] key, input logic [1:0] kl, input logic [127:0] ct);
    keylen = kl;
    blk    = ct;
    expand(key, kl);
  endtask

  typedef struct {
    int           dut;
    logic [1:0]   kl;
    logic [255:0] key;
    logic [127:0] ct;
    int           lat;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int cyc;
    vecs[0]  = '{0, 2'b00, K1, C1, 12};
    vecs[1]  = '{1, 2'b00, K1, C1, 22};
    vecs[2]  = '{2, 2'b00, K1, C1, 42};
    vecs[3]  = '{0, 2'b01, K2, C2, 14};
    vecs[4]  = '{1, 2'b01, K2, C2, 26};
    vecs[5]  = '{2, 2'b01, K2, C2, 50};
    vecs[6]  = '{0, 2'b10, K3, C3, 16};
    vecs[7]  = '{1, 2'b10, K3, C3, 30};
    vecs[8]  = '{2, 2'b10, K3, C3, 58};
    vecs[9]  = '{0, 2'b11, K1, C1, 12};
    vecs[10] = '{2, 2'b11, K1, C1, 42};

    for (int d = 0; d < 3; d++) next_v[d] = 1'b0;
    expand(K1, 2'b00);
    repeat (2) tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_ready[%0d]", d), 128'(ready_v[d]), 128'd1);
      chk($sformatf("reset_round[%0d]", d), 128'(round_v[d]), 128'd0);
      chk($sformatf("reset_block[%0d]", d), nb_v[d], 128'd0);
    end
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < 11; v++) begin
      setup(vecs[v].key, vecs[v].kl, vecs[v].ct);
      start(vecs[v].dut);
      wait_ready(vecs[v].dut, 1, cyc);
      chk($sformatf("vec%0d_latency", v), 128'(cyc), 128'(vecs[v].lat));
      chk($sformatf("vec%0d_plaintext", v), nb_v[vecs[v].dut], PT);
      tick();
    end

    // NUM_SBOX=2, AES-192: round holds for two cycles per step.
    setup(K2, 2'b01, C2);
    start(1);
    chk("hold_round_e0", 128'(round_v[1]), 128'd12);
    tick();
    chk("hold_round_e1", 128'(round_v[1]), 128'd11);
    tick();
    chk("hold_round_e2", 128'(round_v[1]), 128'd11);
    tick();
    chk("hold_round_e3", 128'(round_v[1]), 128'd10);
    wait_ready(1, 4, cyc);
    chk("hold_latency", 128'(cyc), 128'd26);
    chk("hold_plaintext", nb_v[1], PT);
    tick();

    // Second next and a keylen change mid-run are ignored.
    setup(K1, 2'b00, C1);
    start(0);
    repeat (4) tick();
    next_v[0] = 1'b1;
    keylen    = 2'b10;
    tick();
    next_v[0] = 1'b0;
    wait_ready(0, 6, cyc);
    chk("midnext_latency", 128'(cyc), 128'd12);
    chk("midnext_plaintext", nb_v[0], PT);
    tick();

    // next held high: back-to-back operations.
    keylen    = 2'b00;
    next_v[0] = 1'b1;
    tick();
    wait_ready(0, 1, cyc);
    chk("b2b_first_latency", 128'(cyc), 128'd12);
    chk("b2b_first_plaintext", nb_v[0], PT);
    tick();
    chk("b2b_restart_ready", 128'(ready_v[0]), 128'd0);
    next_v[0] = 1'b0;
    wait_ready(0, 1, cyc);
    chk("b2b_second_latency", 128'(cyc), 128'd12);
    chk("b2b_second_plaintext", nb_v[0], PT);
    tick();

    // Asynchronous reset mid-operation.
    start(0);
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk("midreset_ready", 128'(ready_v[0]), 128'd1);
    chk("midreset_round", 128'(round_v[0]), 128'd0);
    chk("midreset_block", nb_v[0], 128'd0);
    tick();
    reset_n = 1'b1;
    tick();
    start(0);
    wait_ready(0, 1, cyc);
    chk("postreset_latency", 128'(cyc), 128'd12);
    chk("postreset_plaintext", nb_v[0], PT);
    tick();

`ifdef AES_DEC_ABORT_EN
    abort     = 1'b1;
    next_v[0] = 1'b1;
    tick();
    abort     = 1'b0;
    next_v[0] = 1'b0;
    chk("idle_abort_next_ready", 128'(ready_v[0]), 128'd1);
    start(0);
    cyc = 1;
    while (round_v[0] != 4'd6 && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("abort_reached_round6", 128'(round_v[0]), 128'd6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ready", 128'(ready_v[0]), 128'd1);
    chk("abort_round", 128'(round_v[0]), 128'd0);
    chk("abort_block", nb_v[0], 128'd0);
    tick();
    chk("abort_stays_idle", 128'(ready_v[0]), 128'd1);
    start(0);
    wait_ready(0, 1, cyc);
    chk("postabort_latency", 128'(cyc), 128'd12);
    chk("postabort_plaintext", nb_v[0], PT);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
